// File: rtl/ysyx_041461_booth_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier: FSM encoding,
// iteration counts and mul_signed field layout.
package ysyx_041461_booth_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StBusy = ST_BUSY,
    StDone = ST_DONE
  } mul_state_e;

  // One Booth window per two multiplier bits, including the 2-bit extension.
  localparam int unsigned ITER64 = 33;
  localparam int unsigned ITER32 = 17;
  localparam int unsigned CNT_W  = 6;

  localparam int unsigned SGN_A_BIT = 1;
  localparam int unsigned SGN_B_BIT = 0;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_SS = 2'b11;

  function automatic logic [CNT_W-1:0] iter_count(input logic mulw);
    return mulw ? CNT_W'(ITER32) : CNT_W'(ITER64);
  endfunction

endpackage

// File: rtl/ysyx_041461_booth_mul_booth_core.sv
// Radix-4 Booth partial-product generator: maps a 3-bit window onto 0, +-X, +-2X.
// Negative products are returned as one's complement plus a carry-in.
module ysyx_041461_Booth_core #(
  parameter int unsigned W = 128
) (
  input  logic [W-1:0] i_x,
  input  logic [2:0]   i_win,
  output logic [W-1:0] o_p,
  output logic         o_c
);

  logic [W-1:0] w_mag;
  logic         w_neg;

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    unique case (i_win)
      3'b000, 3'b111: w_mag = '0;
      3'b001, 3'b010: w_mag = i_x;
      3'b011:         w_mag = {i_x[W-2:0], 1'b0};
      3'b100: begin
        w_mag = {i_x[W-2:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = i_x;
        w_neg = 1'b1;
      end
    endcase
  end

  assign o_p = w_neg ? ~w_mag : w_mag;
  assign o_c = w_neg;

endmodule

// File: rtl/ysyx_041461_booth_mul.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU/MULW), 2 bits per cycle.
// Optional YSYX_041461_MUL_EARLY_EXIT_EN finishes once the remaining multiplier is all sign.
module ysyx_041461_booth_mul
  import ysyx_041461_booth_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mul_valid,
  input  logic            i_flush,
  input  logic            i_mulw,
  input  logic [1:0]      i_mul_signed,
  input  logic [XLEN-1:0] i_multiplicand,
  input  logic [XLEN-1:0] i_multiplier,
  output logic            o_mul_ready,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_result_hi,
  output logic [XLEN-1:0] o_result_lo
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned YW = XLEN + 3;

  mul_state_e       r_state;
  logic [PW-1:0]    r_x;
  logic [PW-1:0]    r_acc;
  logic [YW-1:0]    r_y;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_res_hi;
  logic [XLEN-1:0]  r_res_lo;

  logic             w_accept;
  logic             w_a_ext;
  logic             w_b_ext;
  logic [PW-1:0]    w_x_init;
  logic [YW-1:0]    w_y_init;
  logic [PW-1:0]    w_p;
  logic             w_c;
  logic             w_done_now;

  assign w_accept = i_mul_valid & (r_state == StIdle) & ~i_flush;

  assign w_a_ext = i_mul_signed[SGN_A_BIT] & (i_mulw ? i_multiplicand[31] : i_multiplicand[XLEN-1]);
  assign w_b_ext = i_mul_signed[SGN_B_BIT] & (i_mulw ? i_multiplier[31] : i_multiplier[XLEN-1]);

  always_comb begin
    if (i_mulw) begin
      w_x_init = {{(PW-32){w_a_ext}}, i_multiplicand[31:0]};
      w_y_init = {{(YW-33){w_b_ext}}, i_multiplier[31:0], 1'b0};
    end else begin
      w_x_init = {{XLEN{w_a_ext}}, i_multiplicand};
      w_y_init = {{2{w_b_ext}}, i_multiplier, 1'b0};
    end
  end

  ysyx_041461_Booth_core #(
    .W (PW)
  ) u_booth_core (
    .i_x   (r_x),
    .i_win (r_y[2:0]),
    .o_p   (w_p),
    .o_c   (w_c)
  );

  // The exit cycle never accumulates; the counter reaching zero means all windows are consumed.
`ifdef YSYX_041461_MUL_EARLY_EXIT_EN
  assign w_done_now = (r_cnt == '0) || (r_y == '0) || (&r_y);
`else
  assign w_done_now = (r_cnt == '0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_acc    <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_x     <= w_x_init;
            r_y     <= w_y_init;
            r_acc   <= '0;
            r_cnt   <= iter_count(i_mulw);
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (i_flush) begin
            r_state <= StIdle;
          end else if (w_done_now) begin
            r_res_hi <= r_acc[PW-1:XLEN];
            r_res_lo <= r_acc[XLEN-1:0];
            r_state  <= StDone;
          end else begin
            r_acc <= r_acc + w_p + {{(PW-1){1'b0}}, w_c};
            r_x   <= {r_x[PW-3:0], 2'b00};
            r_y   <= {{2{r_y[YW-1]}}, r_y[YW-1:2]};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_mul_ready = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone) & ~i_flush;
  assign o_result_hi = r_res_hi;
  assign o_result_lo = r_res_lo;

endmodule

// File: tb/tb_ysyx_041461_booth_mul.sv
// Self-checking bench for ysyx_041461_booth_mul: directed cases plus randomized operands
// compared against a plain-arithmetic product model.
module tb_ysyx_041461_booth_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_valid;
  logic        flush;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mul_ready;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_041461_booth_mul #(
    .XLEN (64)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_mul_valid    (mul_valid),
    .i_flush        (flush),
    .i_mulw         (mulw),
    .i_mul_signed   (mul_signed),
    .i_multiplicand (multiplicand),
    .i_multiplier   (multiplier),
    .o_mul_ready    (mul_ready),
    .o_out_valid    (out_valid),
    .o_result_hi    (result_hi),
    .o_result_lo    (result_lo)
  );

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] s, input logic w);
    logic [127:0] ea;
    logic [127:0] eb;
    if (w) begin
      ea = s[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
      eb = s[0] ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
    end else begin
      ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
      eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
    end
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_le(input string tag, input int obs, input int bound);
    n_cmp++;
    assert (obs <= bound) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected <= %0d", tag, obs, bound);
    end
  endtask

  // Accept one operation, wait for its strobe and compare product and latency.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                       input logic w, input string tag);
    int          lat;
    bit          seen;
    logic [127:0] exp;
    exp = ref_mul(a, b, s, w);
    @(negedge clk);
    check({tag, " ready"}, {127'b0, mul_ready}, 128'd1);
    mul_valid    = 1'b1;
    mulw         = w;
    mul_signed   = s;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    mul_valid    = 1'b0;
    multiplicand = {$urandom, $urandom};
    multiplier   = {$urandom, $urandom};
    mulw         = 1'($urandom);
    mul_signed   = 2'($urandom);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) seen = 1;
    end
    check({tag, " strobe"}, {127'b0, seen}, 128'd1);
`ifdef YSYX_041461_MUL_EARLY_EXIT_EN
    check_le({tag, " latency"}, lat, w ? 18 : 34);
`else
    check({tag, " latency"}, 128'(lat), w ? 128'd18 : 128'd34);
`endif
    check({tag, " product"}, {result_hi, result_lo}, exp);
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {127'b0, out_valid}, 128'd0);
    check({tag, " hold"}, {result_hi, result_lo}, exp);
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    bit fired;
    fired = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) fired = 1;
    end
    check(tag, {127'b0, fired}, 128'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          lat;
    bit          seen;

    rst_n        = 1'b0;
    mul_valid    = 1'b0;
    flush        = 1'b0;
    mulw         = 1'b0;
    mul_signed   = 2'b00;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {127'b0, mul_ready}, 128'd1);
    check("reset valid", {127'b0, out_valid}, 128'd0);
    check("reset result", {result_hi, result_lo}, 128'd0);
    rst_n = 1'b1;

    do_op(-64'sd3, 64'd7, 2'b11, 1'b0, "ss_neg3x7");
    check("ss_neg3x7 exact", {result_hi, result_lo},
          {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFEB});
    do_op('1, '1, 2'b00, 1'b0, "uu_max");
    check("uu_max exact", {result_hi, result_lo},
          {64'hFFFFFFFFFFFFFFFE, 64'h0000000000000001});
    do_op('1, '1, 2'b10, 1'b0, "su_max");
    check("su_max exact", {result_hi, result_lo},
          {64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001});
    do_op(64'h0000000080000000, 64'd2, 2'b11, 1'b1, "mulw_min");
    check("mulw_min lo", {64'b0, result_lo}, {64'b0, 64'hFFFFFFFF00000000});
    do_op(64'h8000000000000000, 64'h8000000000000000, 2'b11, 1'b0, "ss_minmin");

    // Flush on the 10th busy cycle.
    @(negedge clk);
    mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b11;
    multiplicand = 64'd123456789; multiplier = 64'd987654321;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy ready", {127'b0, mul_ready}, 128'd1);
    expect_quiet(40, "flush_busy no strobe");
    do_op(64'd6, 64'd7, 2'b00, 1'b0, "after_flush");
    check("after_flush exact", {result_hi, result_lo}, 128'd42);

    // Flush while idle blocks the request.
    @(negedge clk);
    mul_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0; flush = 1'b0;
    check("flush_idle ready", {127'b0, mul_ready}, 128'd1);
    expect_quiet(40, "flush_idle no strobe");

    // Flush in the result cycle suppresses the strobe.
    @(negedge clk);
    mul_valid = 1'b1; mulw = 1'b1; mul_signed = 2'b01;
    multiplicand = 64'd9; multiplier = 64'd11;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) seen = 1;
    end
    check("flush_done reached", {127'b0, seen}, 128'd1);
    flush = 1'b1;
    #1;
    check("flush_done masked", {127'b0, out_valid}, 128'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done ready", {127'b0, mul_ready}, 128'd1);

    // Reset pulse mid-operation.
    @(negedge clk);
    mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b11;
    multiplicand = 64'hDEADBEEFCAFEF00D; multiplier = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset ready", {127'b0, mul_ready}, 128'd1);
    check("midreset valid", {127'b0, out_valid}, 128'd0);
    check("midreset result", {result_hi, result_lo}, 128'd0);
    expect_quiet(40, "midreset no strobe");
    do_op(64'hFFFFFFFF12345678, 64'd1000003, 2'b11, 1'b0, "after_reset");

`ifdef YSYX_041461_MUL_EARLY_EXIT_EN
    @(negedge clk);
    mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b00;
    multiplicand = 64'd5; multiplier = 64'd3;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) seen = 1;
    end
    check("early5x3 strobe", {127'b0, seen}, 128'd1);
    check_le("early5x3 latency", lat, 33);
    check("early5x3 product", {result_hi, result_lo}, 128'd15);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 6 == 0) ra = {1'b1, 63'b0};
      if (i % 7 == 3) rb = '1;
      do_op(ra, rb, 2'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_booth_mul.md
Name: ysyx_041461_booth_mul

Overview:
- Iterative radix-4 Booth multiplier for the EXU M-extension path (MUL/MULH/MULHSU/MULHU/MULW).
- Sits directly upstream of the Booth partial-product generator: each cycle it supplies the 3-bit Booth window and the 128-bit shifted multiplicand, then accumulates the returned partial product and carry-in.
- 64x64 -> 128-bit product; 32-bit (mulw) operands take fewer iterations.

Parameters:
- XLEN, 64, operand width; product is 2*XLEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mul_valid  in  1  request valid
- flush  in  1  cancel any in-flight or requested operation
- mulw  in  1  1 = use low 32 bits of each operand
- mul_signed  in  2  [1] = multiplicand signed, [0] = multiplier signed
- multiplicand  in  XLEN  operand A
- multiplier  in  XLEN  operand B
- mul_ready  out  1  idle, can accept
- out_valid  out  1  one-cycle result strobe
- result_hi  out  XLEN  product[127:64]
- result_lo  out  XLEN  product[63:0]

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state = IDLE, mul_ready = 1, out_valid = 0, result_hi/lo = 0, accumulator and counter = 0.
- Reset wins over everything, including mid-operation; no out_valid is produced for the aborted op.
- States: IDLE, BUSY, DONE.
- mul_ready = (state == IDLE).
- Accept = mul_valid & mul_ready & ~flush.
- Operands are sampled only on accept; inputs are don't-care afterwards.
- Operand preparation on accept:
  - Operand source is the low 32 bits if mulw, else all 64 bits.
  - X = source multiplicand extended to 128 bits (sign if mul_signed[1], else zero).
  - Y = source multiplier extended by 2 bits (sign/zero per mul_signed[0]), with guard bit y[-1] = 0.
  - Y width: 66+1 bits (64-bit op) or 34+1 bits (mulw).
  - Counter N = 33 (64-bit) or 17 (mulw); accumulator = 0.
- BUSY, each cycle:
  - Booth window = {y[1], y[0], y[-1]}; generator returns p (128 bits) and c.
  - acc <= acc + p + c, modulo 2^128.
  - X <<= 2; Y >>= 2 (arithmetic); counter decrements.
  - On the last iteration go to DONE.
- DONE: out_valid = 1 for exactly one cycle; result_hi = acc[127:64], result_lo = acc[63:0]; then back to IDLE.
- result_hi/lo hold their value until the next DONE.
- mulw result: full 64-bit signed/unsigned product of the 32-bit operands on result_lo; sign-truncation to 32 bits is done downstream.
- Latency: accept at edge T -> out_valid high in the cycle after edge T+N+1, i.e. 34 cycles (64-bit) or 18 cycles (mulw).
- Flush:
  - In BUSY: state -> IDLE next edge, no out_valid.
  - In DONE: out_valid is suppressed that cycle, state -> IDLE.
  - In IDLE with mul_valid: request is not accepted.
- No back-to-back accept in the DONE cycle; the earliest new accept is the following IDLE cycle.

Optional Feature:
- YSYX_041461_MUL_EARLY_EXIT_EN.
- Defined: in BUSY, if the remaining Y including the guard bit is all-zeros or all-ones, the remaining windows all encode 0. The block then goes to DONE next edge, and acc is not updated in that cycle.
- Example: 64-bit 5*3 finishes in 3 BUSY cycles.
- Undefined: fixed latency as above. Results are identical either way.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE/BUSY/DONE)
  - iteration counts (ITER64 = 33, ITER32 = 17)
  - mul_signed field encodings
- Sub-module: one instance of the existing ysyx_041461_Booth_core partial-product generator, purely combinational; all sequencing lives in this block.

Test Plan:
- Signed x signed (2'b11), A = -3, B = 7 -> result_hi = 0xFFFFFFFFFFFFFFFF, result_lo = 0xFFFFFFFFFFFFFFEB; out_valid exactly 34 cycles after accept, single-cycle pulse.
- Unsigned (2'b00), A = B = 0xFFFFFFFFFFFFFFFF -> result_hi = 0xFFFFFFFFFFFFFFFE, result_lo = 0x0000000000000001.
- Signed x unsigned (2'b10), A = -1, B = 0xFFFFFFFFFFFFFFFF -> result_hi = 0xFFFFFFFFFFFFFFFF, result_lo = 0x0000000000000001.
- mulw signed, A = 0x0000000080000000, B = 2 -> result_lo = 0xFFFFFFFF00000000; out_valid 18 cycles after accept.
- Flush on the 10th BUSY cycle -> no out_valid, mul_ready = 1 next cycle. A new op 6*7 unsigned is then accepted -> result_lo = 42, result_hi = 0.
- rst_n low for 1 cycle mid-BUSY -> all outputs at reset values; no out_valid. A follow-up op completes correctly. With EARLY_EXIT defined, 5*3 gives result_lo = 15 in fewer than 34 cycles.
